// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: header layout,
// illegal address code, FSM state encodings and the header packing helper.
package router_pkg;

    localparam int DATA_W       = 8;
    localparam int ADDR_W       = 2;
    localparam int LEN_W        = 6;
    localparam int COUNT_W      = 7;
    localparam int MAX_LEN      = 63;
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_LEN_LSB  = 2;

    localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'd3;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT    = 3'd1;
    localparam logic [2:0] ST_HEADER  = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_PARITY  = 3'd4;
    localparam logic [2:0] ST_GAP     = 3'd5;

    function automatic logic [DATA_W-1:0] make_header(input logic [LEN_W-1:0]  len,
                                                      input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_fifo.sv
// Synchronous show-ahead byte FIFO: the head entry is always visible on o_dout,
// a pop simply advances past it. Push is dropped when full, pop when empty.
module router_tx_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic               i_clk,
    input  logic               i_srst,
    input  logic               i_push,
    input  logic [DATA_W-1:0]  i_din,
    input  logic               i_pop,
    output logic [DATA_W-1:0]  o_dout,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_full,
    output logic               o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = COUNT_W'(r_count);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router: buffers payload bytes, then sends
// header, payload and parity on the router input bus, honouring busy.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_LEN    = 63,
    parameter int IFG_CYCLES = 2
) (
    input  logic         clock,
    input  logic         rst,
    input  logic [7:0]   src_data,
    input  logic         src_valid,
    output logic         src_ready,
    input  logic         start,
    input  logic [1:0]   dest_addr,
    input  logic [5:0]   payload_len,
    input  logic         inject_err,
    input  logic         busy,
    output logic [7:0]   pkt_data,
    output logic         pkt_valid,
    output logic         tx_active,
    output logic         done,
    output logic         cfg_err,
    output logic [6:0]   fifo_count
);

    localparam int IFG_W = (IFG_CYCLES < 2) ? 1 : $clog2(IFG_CYCLES);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic              r_inj;
    logic [LEN_W-1:0]  r_remaining;
    logic [DATA_W-1:0] r_parity;
    logic [IFG_W-1:0]  r_ifg;
    logic [DATA_W-1:0] r_pkt_data;
    logic              r_pkt_valid;
    logic              r_done;
    logic              r_cfg_err;

    logic [DATA_W-1:0]  w_fifo_dout;
    logic [COUNT_W-1:0] w_fifo_count;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_pop;
    logic               w_start_bad;
    logic [DATA_W-1:0]  w_header;

    assign w_header    = make_header(r_len, r_addr);
    assign w_start_bad = (payload_len == '0) || (dest_addr == ADDR_ILLEGAL)
                         || (int'(payload_len) > MAX_LEN);

    // Each payload byte is popped at the edge where the previous byte is consumed.
    assign w_pop = !busy && ((r_state == ST_HEADER) ||
                             (r_state == ST_PAYLOAD && r_remaining != '0));

    router_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clock),
        .i_srst  (rst),
        .i_push  (src_valid),
        .i_din   (src_data),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_inj       <= 1'b0;
            r_remaining <= '0;
            r_parity    <= '0;
            r_ifg       <= '0;
            r_pkt_data  <= '0;
            r_pkt_valid <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_start_bad) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_addr  <= dest_addr;
                            r_len   <= payload_len;
                            r_inj   <= inject_err;
                            r_state <= ST_WAIT;
                        end
                    end
                end
                // Hold off until the whole payload is buffered so pkt_valid never gaps.
                ST_WAIT: begin
                    if (w_fifo_count >= {1'b0, r_len}) begin
                        r_pkt_data  <= w_header;
                        r_pkt_valid <= 1'b1;
                        r_parity    <= w_header;
                        r_state     <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (!busy) begin
                        r_pkt_data  <= w_fifo_dout;
                        r_parity    <= r_parity ^ w_fifo_dout;
                        r_remaining <= r_len - 1'b1;
                        r_state     <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (!busy) begin
                        if (r_remaining != '0) begin
                            r_pkt_data  <= w_fifo_dout;
                            r_parity    <= r_parity ^ w_fifo_dout;
                            r_remaining <= r_remaining - 1'b1;
                        end else begin
                            r_pkt_data  <= r_parity ^ {7'd0, r_inj};
                            r_pkt_valid <= 1'b0;
                            r_state     <= ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (!busy) begin
                        r_pkt_data <= '0;
                        r_ifg      <= '0;
                        r_state    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_ifg == IFG_W'(IFG_CYCLES - 1)) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_ifg <= r_ifg + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign src_ready  = !w_fifo_full;
    assign pkt_data   = r_pkt_data;
    assign pkt_valid  = r_pkt_valid;
    assign tx_active  = (r_state != ST_IDLE);
    assign done       = r_done;
    assign cfg_err    = r_cfg_err;
    assign fifo_count = w_fifo_count;

endmodule
